// File: rtl/keypad_entry.sv
// 4x4 active-low keypad scanner with debounce, key decode and 0..100 decimal entry.
// Optional backspace on the D key is enabled by defining KEYPAD_BACKSPACE_EN.
module keypad_entry #(
  parameter int CLKS_PER_COL   = 32768,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] cols,
  input  logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_strobe,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       entry_error,
  output logic [1:0] digit_count
);

  localparam int CW = (CLKS_PER_COL > 1) ? $clog2(CLKS_PER_COL) : 1;
  localparam int MW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t          state;
  logic [3:0]      rows_meta, rows_sync;
  logic [CW-1:0]   dwell;
  logic [MW-1:0]   match_cnt;
  logic [1:0]      col_idx, row_idx, low_idx;
  logic [9:0]      acc, acc_push;
  logic [3:0]      code;
  logic            dwell_end, any_low, row_match, last_match;

  // Row r, column c: digits are their own value, A..D = 10..13, * = 14, # = 15.
  function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_at = 4'd1;   4'h1: key_at = 4'd2;   4'h2: key_at = 4'd3;   4'h3: key_at = 4'd10;
      4'h4: key_at = 4'd4;   4'h5: key_at = 4'd5;   4'h6: key_at = 4'd6;   4'h7: key_at = 4'd11;
      4'h8: key_at = 4'd7;   4'h9: key_at = 4'd8;   4'hA: key_at = 4'd9;   4'hB: key_at = 4'd12;
      4'hC: key_at = 4'd14;  4'hD: key_at = 4'd0;   4'hE: key_at = 4'd15;  default: key_at = 4'd13;
    endcase
  endfunction

  assign cols       = ~(4'b0001 << col_idx);
  assign dwell_end  = (dwell == CW'(CLKS_PER_COL - 1));
  assign any_low    = (rows_sync != 4'hF);
  assign row_match  = any_low && (low_idx == row_idx);
  assign last_match = (match_cnt == MW'(DEBOUNCE_SCANS - 1));
  assign code       = key_at(row_idx, col_idx);
  assign acc_push   = acc * 10'd10 + {6'd0, code};

  always_comb begin
    low_idx = 2'd3;
    if (!rows_sync[0])      low_idx = 2'd0;
    else if (!rows_sync[1]) low_idx = 2'd1;
    else if (!rows_sync[2]) low_idx = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCAN;
      rows_meta   <= 4'hF;
      rows_sync   <= 4'hF;
      dwell       <= '0;
      match_cnt   <= '0;
      col_idx     <= 2'd0;
      row_idx     <= 2'd0;
      acc         <= 10'd0;
      key_code    <= 4'd0;
      key_strobe  <= 1'b0;
      value       <= 8'd0;
      value_valid <= 1'b0;
      entry_error <= 1'b0;
      digit_count <= 2'd0;
    end else begin
      rows_meta   <= rows;
      rows_sync   <= rows_meta;
      dwell       <= dwell_end ? '0 : dwell + CW'(1);
      key_strobe  <= 1'b0;
      value_valid <= 1'b0;
      entry_error <= 1'b0;
      case (state)
        SCAN: if (dwell_end) begin
          if (any_low) begin
            row_idx   <= low_idx;
            match_cnt <= '0;
            state     <= DEBOUNCE;
          end else begin
            col_idx <= col_idx + 2'd1;
          end
        end
        DEBOUNCE: if (dwell_end) begin
          if (!row_match) begin
            state   <= SCAN;
            col_idx <= col_idx + 2'd1;
          end else if (!last_match) begin
            match_cnt <= match_cnt + MW'(1);
          end else begin
            // Outputs are registered here so they are visible during the PRESSED cycle.
            state      <= PRESSED;
            match_cnt  <= '0;
            key_strobe <= 1'b1;
            key_code   <= code;
            if (code < 4'd10) begin
              if (digit_count != 2'd3) begin
                acc         <= acc_push;
                digit_count <= digit_count + 2'd1;
              end
            end else if (code == 4'd14) begin
              acc         <= 10'd0;
              digit_count <= 2'd0;
            end else if (code == 4'd15) begin
              if (digit_count != 2'd0) begin
                if (acc <= 10'd100) begin
                  value       <= acc[7:0];
                  value_valid <= 1'b1;
                end else begin
                  entry_error <= 1'b1;
                end
                acc         <= 10'd0;
                digit_count <= 2'd0;
              end
            end
`ifdef KEYPAD_BACKSPACE_EN
            else if (code == 4'd13) begin
              if (digit_count != 2'd0) begin
                acc         <= acc / 10'd10;
                digit_count <= digit_count - 2'd1;
              end
            end
`endif
          end
        end
        PRESSED: state <= RELEASE;
        RELEASE: if (dwell_end) begin
          if (any_low) begin
            match_cnt <= '0;
          end else if (!last_match) begin
            match_cnt <= match_cnt + MW'(1);
          end else begin
            match_cnt <= '0;
            state     <= SCAN;
            col_idx   <= col_idx + 2'd1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule
